// File: rtl/a2_seq_pkg.sv
// Shared types and defaults for the Apple II phi0 bus-cycle sequencer.
// Contents:
//   seq_state_t   - sequencer FSM state (IDLE / ACQUIRE / LOCKED)
//   DEF_*         - default parameter values
//   within_tol()  - absolute-difference tolerance test for period values
package a2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } seq_state_t;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_CYCLES = 4;
  localparam int DEF_TOL         = 2;
  localparam int DEF_TIMEOUT     = 255;

  // True when |a - b| <= tol (inclusive).
  function automatic logic within_tol(input int unsigned a,
                                      input int unsigned b,
                                      input int unsigned tol);
    int unsigned diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return diff <= tol;
  endfunction

endpackage

// File: rtl/phi0_period_meter.sv
// Phase counter, saturating period capture and edge-starvation timer.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   pos_edge     - phi0 rose this cycle (clears the phase counter)
//   any_edge     - either phi0 edge this cycle (restarts the idle timer)
//   capture      - load period with the measured distance this cycle
//   phase_next   - phase counter value for the next cycle
//   period_meas  - distance from the previous posedge to this cycle
//   period       - last captured period (registered)
//   timeout      - TIMEOUT cycles have passed without any edge
module phi0_period_meter
  import a2_seq_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pos_edge,
  input  logic             any_edge,
  input  logic             capture,
  output logic [CNT_W-1:0] phase_next,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] phase_reg;
  logic [CNT_W-1:0] idle_reg;
  logic [CNT_W-1:0] idle_next;
  logic [CNT_W-1:0] period_reg;

  always_comb begin
    phase_next  = pos_edge ? '0
                : (phase_reg == CNT_MAX) ? CNT_MAX : phase_reg + CNT_ONE;
    // phase_reg is 0 the cycle after a posedge, so +1 gives the pulse distance.
    period_meas = (phase_reg == CNT_MAX) ? CNT_MAX : phase_reg + CNT_ONE;
    // The idle timer holds the number of edge-free cycles elapsed; it parks at
    // TIMEOUT so the starvation flag stays up until the next edge.
    idle_next   = any_edge ? CNT_ONE
                : (idle_reg == TIMEOUT_VAL) ? TIMEOUT_VAL : idle_reg + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg  <= '0;
      idle_reg   <= '0;
      period_reg <= '0;
    end else begin
      phase_reg <= phase_next;
      idle_reg  <= idle_next;
      if (capture) begin
        period_reg <= period_meas;
      end
    end
  end

  assign period  = period_reg;
  assign timeout = (idle_reg == TIMEOUT_VAL);

endmodule

// File: rtl/phi0_sequencer.sv
// Locks onto the phi0 edge pulses of the Apple II bus and emits per-bus-cycle
// address-sample, data-sample and end-of-cycle strobes.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   phi0_posedge_i     - one-cycle pulse, phi0 rose
//   phi0_negedge_i     - one-cycle pulse, phi0 fell
//   addr_ofs_i         - addr_strobe offset from posedge (sampled on posedge)
//   data_ofs_i         - data_strobe offset from posedge (sampled on posedge)
//   locked_o           - schedule locked
//   lost_o             - one-cycle pulse when lock is dropped
//   addr_strobe_o      - one-cycle address-sample strobe
//   data_strobe_o      - one-cycle data-sample strobe
//   end_strobe_o       - one-cycle pulse per phi0 negedge while locked
//   period_o           - last measured posedge-to-posedge period
module phi0_sequencer
  import a2_seq_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int TOL         = DEF_TOL,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phi0_posedge_i,
  input  logic             phi0_negedge_i,
  input  logic [CNT_W-1:0] addr_ofs_i,
  input  logic [CNT_W-1:0] data_ofs_i,
  output logic             locked_o,
  output logic             lost_o,
  output logic             addr_strobe_o,
  output logic             data_strobe_o,
  output logic             end_strobe_o,
  output logic [CNT_W-1:0] period_o
);

  localparam int MATCH_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CYCLES);
  localparam int N_STB = 2;  // channel 0: address, channel 1: data

  seq_state_t       state_reg;
  logic [MATCH_W-1:0] match_reg;
  logic [MATCH_W-1:0] match_inc;
  logic             have_prev_reg;
  logic [CNT_W-1:0] ref_reg;
  logic [CNT_W-1:0] ofs_reg [N_STB];
  logic [CNT_W-1:0] ofs_in  [N_STB];
  logic [N_STB-1:0] fired_reg;
  logic [N_STB-1:0] fire;

  logic             violation;
  logic             any_edge;
  logic             starved;
  logic             capture;
  logic             match_prev;
  logic             match_ref;
  logic [CNT_W-1:0] phase_next;
  logic [CNT_W-1:0] period_meas;
  logic             timeout;

  assign ofs_in[0] = addr_ofs_i;
  assign ofs_in[1] = data_ofs_i;

  assign violation = phi0_posedge_i & phi0_negedge_i;
  assign any_edge  = phi0_posedge_i | phi0_negedge_i;
  // Starvation only matters once a schedule is being tracked.
  assign starved   = timeout & (state_reg != IDLE);
  // The first posedge out of IDLE only starts the phase counter.
  assign capture   = phi0_posedge_i & ~phi0_negedge_i & (state_reg != IDLE) & ~starved;
  assign match_inc = match_reg + MATCH_ONE;
  // With no previous period yet, the first measurement counts as consistent.
  assign match_prev = ~have_prev_reg |
                      within_tol(32'(period_meas), 32'(period_o), $unsigned(TOL));
  assign match_ref  = within_tol(32'(period_meas), 32'(ref_reg), $unsigned(TOL));

  phi0_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_meter (
    .clk         (clk),
    .rst         (rst),
    .pos_edge    (phi0_posedge_i),
    .any_edge    (any_edge),
    .capture     (capture),
    .phase_next  (phase_next),
    .period_meas (period_meas),
    .period      (period_o),
    .timeout     (timeout)
  );

  // A strobe fires when the phase reaches its offset, or is forced by the
  // negedge if it has not fired yet; a posedge re-arms it and uses the live
  // offset, since the sampled copy only lands the cycle after.
  for (genvar gi = 0; gi < N_STB; gi++) begin : g_stb
    logic             fired_base;
    logic [CNT_W-1:0] ofs_cur;
    assign fired_base = phi0_posedge_i ? 1'b0 : fired_reg[gi];
    assign ofs_cur    = phi0_posedge_i ? ofs_in[gi] : ofs_reg[gi];
    assign fire[gi]   = ~fired_base & ((phase_next == ofs_cur) | phi0_negedge_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      match_reg     <= '0;
      have_prev_reg <= 1'b0;
      ref_reg       <= '0;
      fired_reg     <= '0;
      for (int i = 0; i < N_STB; i++) ofs_reg[i] <= '0;
      locked_o      <= 1'b0;
      lost_o        <= 1'b0;
      addr_strobe_o <= 1'b0;
      data_strobe_o <= 1'b0;
      end_strobe_o  <= 1'b0;
    end else begin
      lost_o        <= 1'b0;
      addr_strobe_o <= 1'b0;
      data_strobe_o <= 1'b0;
      end_strobe_o  <= 1'b0;
      if (phi0_posedge_i) begin
        for (int i = 0; i < N_STB; i++) ofs_reg[i] <= ofs_in[i];
      end

      if (violation || starved) begin
        state_reg     <= IDLE;
        lost_o        <= (state_reg == LOCKED);
        locked_o      <= 1'b0;
        match_reg     <= '0;
        have_prev_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (phi0_posedge_i) begin
              state_reg     <= ACQUIRE;
              match_reg     <= '0;
              have_prev_reg <= 1'b0;
            end
          end
          ACQUIRE: begin
            if (phi0_posedge_i) begin
              have_prev_reg <= 1'b1;
              if (match_prev) begin
                if (match_inc == MATCH_LOCK) begin
                  state_reg <= LOCKED;
                  locked_o  <= 1'b1;
                  ref_reg   <= period_meas;
                  match_reg <= '0;
                  // The locking bus cycle is already under way: hold strobes
                  // off until the next posedge.
                  fired_reg <= '1;
                end else begin
                  match_reg <= match_inc;
                end
              end else begin
                match_reg <= '0;
              end
            end
          end
          LOCKED: begin
            if (phi0_posedge_i && !match_ref) begin
              state_reg     <= ACQUIRE;
              lost_o        <= 1'b1;
              locked_o      <= 1'b0;
              match_reg     <= '0;
              have_prev_reg <= 1'b0;
            end else begin
              addr_strobe_o <= fire[0];
              data_strobe_o <= fire[1];
              end_strobe_o  <= phi0_negedge_i;
              for (int i = 0; i < N_STB; i++) begin
                fired_reg[i] <= (phi0_posedge_i ? 1'b0 : fired_reg[i]) | fire[i];
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phi0_sequencer.sv
// Directed self-checking bench for phi0_sequencer (default parameters:
// CNT_W=8, LOCK_CYCLES=4, TOL=2, TIMEOUT=255).
// A bus cycle is driven as `len` clk steps: posedge pulse at step 0, negedge
// pulse at step neg_at. After step s the outputs seen are those of cycle
// N+1+s, so bit s of each capture mask is the output in cycle N+1+s.
module tb_phi0_sequencer;

  logic       clk;
  logic       rst;
  logic       phi0_pos;
  logic       phi0_neg;
  logic [7:0] addr_ofs;
  logic [7:0] data_ofs;
  logic       locked;
  logic       lost;
  logic       addr_strobe;
  logic       data_strobe;
  logic       end_strobe;
  logic [7:0] period;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] am, dm, em, lm, km;
  logic [7:0]  p0;

  phi0_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .phi0_posedge_i (phi0_pos),
    .phi0_negedge_i (phi0_neg),
    .addr_ofs_i     (addr_ofs),
    .data_ofs_i     (data_ofs),
    .locked_o       (locked),
    .lost_o         (lost),
    .addr_strobe_o  (addr_strobe),
    .data_strobe_o  (data_strobe),
    .end_strobe_o   (end_strobe),
    .period_o       (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("chk %-18s got=0x%0h exp=0x%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-18s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic p, input logic n);
    phi0_pos = p;
    phi0_neg = n;
    @(posedge clk);
    #1;
    phi0_pos = 1'b0;
    phi0_neg = 1'b0;
  endtask

  // Offsets are valid on the posedge step only, then scrambled so that a
  // design reading them live would misplace its strobes.
  task automatic bus_cycle(input int len, input int neg_at,
                           input logic [7:0] a, input logic [7:0] d);
    am = '0; dm = '0; em = '0; lm = '0; km = '0;
    addr_ofs = a;
    data_ofs = d;
    for (int s = 0; s < len; s++) begin
      step(s == 0, s == neg_at);
      if (s == 0) begin
        addr_ofs = ~a;
        data_ofs = ~d;
        p0 = period;
      end
      am[s] = addr_strobe;
      dm[s] = data_strobe;
      em[s] = end_strobe;
      lm[s] = lost;
      km[s] = locked;
    end
  endtask

  task automatic lock_up();
    for (int b = 0; b < 5; b++) bus_cycle(14, 7, 8'd2, 8'd5);
  endtask

  initial begin
    int lost_cnt;
    int first_j;
    logic [7:0] pv;

    rst = 1'b1; phi0_pos = 1'b0; phi0_neg = 1'b0;
    addr_ofs = 8'd2; data_ofs = 8'd5;
    @(posedge clk); #1;
    step(0, 0);
    check("reset_outputs", 32'({locked, lost, addr_strobe, data_strobe, end_strobe, period}), 32'd0);
    rst = 1'b0;

    // Acquire lock on a steady 14-cycle period.
    for (int b = 1; b <= 4; b++) begin
      bus_cycle(14, 7, 8'd2, 8'd5);
      if (b == 4) check("pre_lock_locked", km, 32'h0);
    end
    bus_cycle(14, 7, 8'd2, 8'd5);
    check("lock_rise", km, 32'h3FFF);
    check("lock_cycle_addr", am, 32'h0);
    check("lock_cycle_data", dm, 32'h0);
    check("lock_period", 32'(p0), 32'd14);

    // Normal strobe placement.
    bus_cycle(14, 7, 8'd2, 8'd5);
    check("c6_addr", am, 32'h4);
    check("c6_data", dm, 32'h20);
    check("c6_end", em, 32'h80);
    check("c6_lost", lm, 32'h0);
    check("c6_locked", km, 32'h3FFF);

    bus_cycle(14, 7, 8'd0, 8'd6);
    check("c7_addr_ofs0", am, 32'h1);
    check("c7_data_ofs6", dm, 32'h40);

    // Offsets beyond the negedge are forced onto the end strobe, once.
    bus_cycle(14, 7, 8'd2, 8'd10);
    check("c8_addr", am, 32'h4);
    check("c8_data_forced", dm, 32'h80);
    check("c8_end", em, 32'h80);

    bus_cycle(14, 7, 8'd9, 8'd13);
    check("c9_addr_forced", am, 32'h80);
    check("c9_data_forced", dm, 32'h80);

    // Deviation of exactly TOL keeps lock.
    bus_cycle(16, 7, 8'd2, 8'd5);
    bus_cycle(14, 7, 8'd2, 8'd5);
    check("tol_edge_lost", lm, 32'h0);
    check("tol_edge_locked", km, 32'h3FFF);
    check("tol_edge_period", 32'(p0), 32'd16);

    // Deviation of 3 drops lock, relock after four 14-cycle periods.
    bus_cycle(17, 7, 8'd2, 8'd5);
    bus_cycle(14, 7, 8'd2, 8'd5);
    check("dev_period", 32'(p0), 32'd17);
    check("dev_lost", lm, 32'h1);
    check("dev_locked", km, 32'h0);
    check("dev_no_strobe", am, 32'h0);
    bus_cycle(14, 7, 8'd2, 8'd5);
    bus_cycle(14, 7, 8'd2, 8'd5);
    bus_cycle(14, 7, 8'd2, 8'd5);
    check("relock_pending", km, 32'h0);
    bus_cycle(14, 7, 8'd2, 8'd5);
    check("relock", km, 32'h3FFF);

    // Starvation while locked.
    bus_cycle(14, 7, 8'd2, 8'd5);
    lost_cnt = 0; first_j = -1;
    for (int j = 0; j < 300; j++) begin
      step(0, 0);
      if (lost) begin
        lost_cnt++;
        if (first_j < 0) first_j = j;
      end
    end
    check("starve_lock_lost", 32'(lost_cnt), 32'd1);
    check("starve_lock_when", 32'(first_j >= 240 && first_j <= 260), 32'd1);
    check("starve_lock_lck", 32'(locked), 32'd0);
    pv = period;
    step(1, 0);
    check("starve_idle_nomeas", 32'(period), 32'(pv));

    // Starvation while acquiring.
    bus_cycle(14, 7, 8'd2, 8'd5);
    bus_cycle(14, 7, 8'd2, 8'd5);
    lost_cnt = 0;
    for (int j = 0; j < 300; j++) begin
      step(0, 0);
      if (lost) lost_cnt++;
    end
    check("starve_acq_lost", 32'(lost_cnt), 32'd0);
    check("starve_acq_lck", 32'(locked), 32'd0);

    // Reset mid-lock.
    lock_up();
    check("rst_relock", km, 32'h3FFF);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    rst = 1'b1;
    step(0, 0);
    check("rst_mid_outputs", 32'({locked, lost, addr_strobe, data_strobe, end_strobe, period}), 32'd0);
    rst = 1'b0;
    lost_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step(0, 0);
      if (lost) lost_cnt++;
    end
    check("rst_mid_no_lost", 32'(lost_cnt), 32'd0);

    // Simultaneous edges while locked.
    lock_up();
    check("viol_relock", km, 32'h3FFF);
    step(1, 1);
    check("viol_lost_lck", 32'({locked, lost}), 32'b01);
    step(0, 0);
    check("viol_lost_single", 32'(lost), 32'd0);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    check("viol_idle_nomeas", 32'(period), 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phi0_sequencer.md
# phi0_sequencer

- Turns the synchronized single-cycle phi0 edge pulses of the Apple II bus into a locked per-bus-cycle schedule.
- Measures the phi0 period and declares lock after a run of consistent periods.
- Emits address-sample, data-sample and end-of-cycle strobes at programmable offsets, and flags loss of the bus clock.
- Sits between the bus edge synchronizers and the bus-slave logic, in the fast `clk` domain.

## Interface
Parameters:
- CNT_W, 8: width of period, phase and offset counters.
- LOCK_CYCLES, 4: consecutive matching periods required for lock (≥1).
- TOL, 2: allowed period deviation in clk cycles (inclusive).
- TIMEOUT, 255: clk cycles without any phi0 edge before clock loss (< 2^CNT_W).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- phi0_posedge_i  in  1  one-cycle pulse, phi0 rose.
- phi0_negedge_i  in  1  one-cycle pulse, phi0 fell.
- addr_ofs_i  in  CNT_W  addr_strobe offset from posedge.
- data_ofs_i  in  CNT_W  data_strobe offset from posedge.
- locked_o  out  1  schedule locked.
- lost_o  out  1  one-cycle pulse, lock dropped.
- addr_strobe_o  out  1  one-cycle address-sample strobe.
- data_strobe_o  out  1  one-cycle data-sample strobe.
- end_strobe_o  out  1  one-cycle pulse on each phi0 negedge while locked.
- period_o  out  CNT_W  last measured posedge-to-posedge period.

## Operation
States:
- IDLE: waiting for the first edge.
- ACQUIRE: measuring periods and counting matches.
- LOCKED: emitting strobes.

Reset:
- Synchronous; any cycle with rst=1 forces IDLE and clears all counters.
- All outputs are 0 in the cycle after rst, including period_o. Reset mid-operation behaves the same: no lost pulse is emitted.

Phase counter:
- Cleared on a posedge pulse, otherwise +1 per cycle.
- Saturates at 2^CNT_W−1.

Period measurement:
- The first posedge after IDLE only starts the phase counter.
- Every later posedge: period = phase+1, i.e. the clk-cycle distance between the two pulses, saturating. period_o is loaded with it.

Transitions:
- IDLE → ACQUIRE on posedge. match_cnt=0.
- ACQUIRE, on each measured period:
  - |period − previous period| ≤ TOL: match_cnt+1.
  - Otherwise: match_cnt=0.
  - When match_cnt reaches LOCK_CYCLES: go to LOCKED.
- LOCKED, measured period deviates > TOL from the locked reference period: pulse lost_o, go to ACQUIRE with match_cnt=0.
- Any state, idle counter reaches TIMEOUT:
  - The idle counter counts cycles since the last edge of either polarity.
  - Go to IDLE. lost_o pulses only if the state was LOCKED.
- Posedge and negedge in the same cycle: protocol violation.
  - Go to IDLE. lost_o pulses if the state was LOCKED.
  - Neither edge is measured.

Strobes:
- Emitted only in LOCKED, each at most once per bus cycle.
- addr_strobe_o fires when the phase counter equals addr_ofs_i. data_strobe_o likewise with data_ofs_i.
- If a negedge arrives before a strobe has fired in that cycle, the strobe is forced on the negedge cycle, together with end_strobe_o.
- Offsets are sampled on each posedge and held for the bus cycle.

## Timing
- All outputs are registered.
- Posedge pulse at cycle N:
  - The offset-k strobe is high exactly in cycle N+1+k.
  - period_o updates in cycle N+1.
  - locked_o rises in N+1 on the locking posedge.
- Negedge pulse at cycle M:
  - end_strobe_o and any forced strobes are high in M+1.
- locked_o falls in the same cycle lost_o pulses.
- Timeout is detected at idle count == TIMEOUT. lost_o and locked_o=0 follow in the next cycle.
- A posedge that causes lock does not itself produce strobes; strobes begin with the next bus cycle.

## Structure
- Package a2_seq_pkg holds:
  - seq_state_t enum {IDLE, ACQUIRE, LOCKED}.
  - Default parameter constants.
  - A within_tol() function.
- Sub-module phi0_period_meter contains the phase counter, saturating period capture and idle/timeout counter.
- The top level holds the FSM and strobe generation.

## Test plan
- Steady 14-cycle period (posedge every 14, negedge at +7), LOCK_CYCLES=4 → locked_o rises 1 cycle after the 5th posedge; period_o=14.
- Locked, addr_ofs=2, data_ofs=5 → addr_strobe at posedge+3, data_strobe at posedge+6, end_strobe at negedge+1, once each per cycle.
- Locked, data_ofs=10 with negedge at +7 → data_strobe forced on negedge+1 alongside end_strobe, not repeated later.
- Locked at 14, one period of 17 (TOL=2) → lost_o single pulse, locked_o=0, relock after 4 further 14-cycle periods.
- Edges stop for 255 cycles while locked → lost_o pulse, state IDLE. Same starvation in ACQUIRE → no lost_o.
- rst asserted mid-lock, and simultaneous posedge+negedge while locked → all outputs 0 after rst with no lost_o; simultaneous edges give lost_o=1 then IDLE.
